usb_tx_packetizer: RTL and testbench

Parametrised USB full-speed transmit packetizer that serialises complete packets onto the D+/D- pair: SYNC, PID (any handshake or DATA0/DATA1), payload, CRC16, bit stuffing, NRZI encoding and EOP. It supersedes the fixed-function TX encoder. Bit period, maximum payload length and EOP shape are configurable. Payload is pulled through a one-byte holding register with a valid/ready handshake, which replaces the occupancy-polling scheme. It sits between the endpoint TX FIFO and the USB transceiver pins.

---
 rtl/usb_pkg.sv | 51 +++++
 rtl/usb_crc16_serial.sv | 41 ++++
 rtl/usb_tx_packetizer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit path: PID codes, line
// encodings, CRC16 constants and the packetizer FSM state type.
package usb_pkg;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    // Line state as {dp, dm}.
    typedef logic [1:0] line_t;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Sent LSB first, giving 0000_0001 on the bit stream (KJKJKJKK).
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    localparam logic [2:0] MAX_ONES = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    function automatic logic pid_is_data(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic pid_is_legal(input logic [3:0] pid);
        return pid_is_data(pid) || (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

    // NRZI: a 0 toggles between J and K, a 1 holds the line.
    function automatic line_t nrzi_next(input line_t cur, input logic b);
        if (b) begin
            return cur;
        end
        return (cur == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial USB CRC16 (x^16+x^15+x^2+1); crc_out is presented bit-reversed so
// that its complement can be sent LSB first as USB requires.
module usb_crc16_serial
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q, crc_d;
    logic        feedback;

    always_comb begin
        feedback = crc_q[15] ^ data_in;
        crc_d    = crc_q;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (shift) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            crc_out[i] = crc_q[15 - i];
        end
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB full-speed transmit packetizer: SYNC, PID, payload, CRC16, bit stuffing,
// NRZI and EOP onto D+/D-, fed through a one-byte valid/ready holding register.
module usb_tx_packetizer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int LEN_W        = 7,
    parameter int EOP_SE0_BITS = 2,
    parameter int EOP_J_BITS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_data_valid,
    output logic             tx_data_ready,
    output logic             dp,
    output logic             dm,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       ones_q, ones_d;
    line_t            line_q, line_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [LEN_W-1:0] accept_left_q, accept_left_d;
    logic [LEN_W-1:0] load_left_q, load_left_d;
    logic             is_data_q, is_data_d;
    logic             underrun_q, underrun_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic       bit_tick, stuff_now;
    logic [7:0] idx_inc;
    logic       emit, emit_bit, emit_counted;
    logic       go_reload, go_crc, go_eop;
    logic       crc_clear, crc_shift, crc_bit;
    logic [15:0] crc_out;

    assign bit_tick  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stuff_now = (state_q inside {ST_PID, ST_DATA, ST_CRC}) && (ones_q == MAX_ONES);
    assign idx_inc   = idx_q + 8'd1;

    assign tx_data_ready = (state_q inside {ST_SYNC, ST_PID, ST_DATA}) && !hold_full_q
                           && (accept_left_q != '0);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        byte_d        = byte_q;
        ones_d        = ones_q;
        line_d        = line_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        accept_left_d = accept_left_q;
        load_left_d   = load_left_q;
        is_data_d     = is_data_q;
        underrun_d    = underrun_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        emit_counted  = 1'b0;
        go_reload     = 1'b0;
        go_crc        = 1'b0;
        go_eop        = 1'b0;
        crc_clear     = 1'b0;
        crc_shift     = 1'b0;
        crc_bit       = 1'b0;

        if (tx_data_ready && tx_data_valid) begin
            hold_d        = tx_data;
            hold_full_d   = 1'b1;
            accept_left_d = accept_left_q - LEN_W'(1);
        end

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (tx_start) begin
                if (pid_is_legal(tx_pid)) begin
                    state_d       = ST_SYNC;
                    idx_d         = '0;
                    ones_d        = '0;
                    byte_d        = {~tx_pid, tx_pid};
                    is_data_d     = pid_is_data(tx_pid);
                    accept_left_d = pid_is_data(tx_pid) ? tx_len : '0;
                    load_left_d   = pid_is_data(tx_pid) ? tx_len : '0;
                    underrun_d    = 1'b0;
                    hold_full_d   = 1'b0;
                    crc_clear     = 1'b1;
                    emit          = 1'b1;
                    emit_bit      = SYNC_PATTERN[0];
                end else begin
                    error_d = 1'b1;
                end
            end
        end else begin
            cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
            if (bit_tick) begin
                if (stuff_now) begin
                    // Stuffed 0 occupies a bit time without advancing data or CRC.
                    emit         = 1'b1;
                    emit_bit     = 1'b0;
                    emit_counted = 1'b1;
                end else begin
                    unique case (state_q)
                        ST_SYNC: begin
                            if (idx_q != 8'd7) begin
                                idx_d    = idx_inc;
                                emit     = 1'b1;
                                emit_bit = SYNC_PATTERN[idx_inc[2:0]];
                            end else begin
                                state_d      = ST_PID;
                                idx_d        = '0;
                                emit         = 1'b1;
                                emit_bit     = byte_q[0];
                                emit_counted = 1'b1;
                            end
                        end
                        ST_PID: begin
                            if (idx_q != 8'd7) begin
                                idx_d        = idx_inc;
                                emit         = 1'b1;
                                emit_bit     = byte_q[idx_inc[2:0]];
                                emit_counted = 1'b1;
                            end else if (!is_data_q) begin
                                go_eop = 1'b1;
                            end else if (load_left_q == '0) begin
                                go_crc = 1'b1;
                            end else begin
                                go_reload = 1'b1;
                            end
                        end
                        ST_DATA: begin
                            if (idx_q != 8'd7) begin
                                idx_d        = idx_inc;
                                emit         = 1'b1;
                                emit_bit     = byte_q[idx_inc[2:0]];
                                emit_counted = 1'b1;
                                crc_shift    = 1'b1;
                                crc_bit      = byte_q[idx_inc[2:0]];
                            end else if (load_left_q == '0) begin
                                go_crc = 1'b1;
                            end else begin
                                go_reload = 1'b1;
                            end
                        end
                        ST_CRC: begin
                            if (idx_q != 8'd15) begin
                                idx_d        = idx_inc;
                                emit         = 1'b1;
                                emit_bit     = ~crc_out[idx_inc[3:0]];
                                emit_counted = 1'b1;
                            end else begin
                                go_eop = 1'b1;
                            end
                        end
                        ST_EOP_SE0: begin
                            if (idx_q == 8'(EOP_SE0_BITS - 1)) begin
                                state_d = ST_EOP_J;
                                idx_d   = '0;
                                line_d  = LINE_J;
                            end else begin
                                idx_d = idx_inc;
                            end
                        end
                        ST_EOP_J: begin
                            if (idx_q == 8'(EOP_J_BITS - 1)) begin
                                state_d = ST_IDLE;
                                idx_d   = '0;
                                done_d  = !underrun_q;
                            end else begin
                                idx_d = idx_inc;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end

        // Byte boundary: take the next payload byte, or abort on an empty holding register.
        if (go_reload) begin
            if (hold_full_q) begin
                state_d      = ST_DATA;
                idx_d        = '0;
                byte_d       = hold_q;
                hold_full_d  = 1'b0;
                load_left_d  = load_left_q - LEN_W'(1);
                emit         = 1'b1;
                emit_bit     = hold_q[0];
                emit_counted = 1'b1;
                crc_shift    = 1'b1;
                crc_bit      = hold_q[0];
            end else begin
                error_d    = 1'b1;
                underrun_d = 1'b1;
                go_eop     = 1'b1;
            end
        end

        if (go_crc) begin
            state_d      = ST_CRC;
            idx_d        = '0;
            emit         = 1'b1;
            emit_bit     = ~crc_out[0];
            emit_counted = 1'b1;
        end

        if (go_eop) begin
            state_d = ST_EOP_SE0;
            idx_d   = '0;
            line_d  = LINE_SE0;
        end

        if (emit) begin
            line_d = nrzi_next(line_q, emit_bit);
            if (emit_counted) begin
                ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            byte_q        <= '0;
            ones_q        <= '0;
            line_q        <= LINE_J;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            accept_left_q <= '0;
            load_left_q   <= '0;
            is_data_q     <= 1'b0;
            underrun_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            byte_q        <= byte_d;
            ones_q        <= ones_d;
            line_q        <= line_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            accept_left_q <= accept_left_d;
            load_left_q   <= load_left_d;
            is_data_q     <= is_data_d;
            underrun_q    <= underrun_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    usb_crc16_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .clear   (crc_clear),
        .shift   (crc_shift),
        .data_in (crc_bit),
        .crc_out (crc_out)
    );

    assign dp       = line_q[1];
    assign dm       = line_q[0];
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = done_q;
    assign tx_error = error_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Self-checking bench for usb_tx_packetizer: table of packets, expected line
// symbols queued from a bit-level encoder model and compared once per bit time.
module tb_usb_tx_packetizer;
    import usb_pkg::*;

    localparam int CPB   = 8;
    localparam int LEN_W = 7;
    localparam int NV    = 9;
    localparam int WAIT_LIMIT = 5000;

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_start;
    logic [3:0]       tx_pid;
    logic [LEN_W-1:0] tx_len;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_data_ready;
    logic             dp, dm, tx_busy, tx_done, tx_error;

    always #5 clk = ~clk;

    usb_tx_packetizer #(
        .CLKS_PER_BIT (CPB),
        .LEN_W        (LEN_W),
        .EOP_SE0_BITS (2),
        .EOP_J_BITS   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_len        (tx_len),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .dp            (dp),
        .dm            (dm),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    typedef struct {
        logic [3:0]       pid;
        logic [LEN_W-1:0] len;
        logic [31:0]      data;      // byte i in data[8*i +: 8]
        int               n_valid;   // bytes the feeder offers
        int               exp_done;
        int               exp_err;
        int               exp_bits;  // fixed active bit count, 0 = use model
        bit               no_ready;
    } vec_t;

    vec_t  vecs [NV];
    int    n_checks = 0;
    int    n_errors = 0;

    int busy_cyc = 0, done_cnt = 0, err_cnt = 0, ready_cyc = 0;
    always @(negedge clk) begin
        if (tx_busy === 1'b1)       busy_cyc++;
        if (tx_done === 1'b1)       done_cnt++;
        if (tx_error === 1'b1)      err_cnt++;
        if (tx_data_ready === 1'b1) ready_cyc++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference encoder ----------------
    line_t sb [$];
    line_t mline;
    int    mones;

    function automatic line_t toggle(input line_t l);
        return (l == 2'b10) ? 2'b01 : 2'b10;
    endfunction

    function automatic bit ref_legal(input logic [3:0] p);
        return p == 4'b0010 || p == 4'b1010 || p == 4'b1110 || p == 4'b0011 || p == 4'b1011;
    endfunction

    function automatic logic [15:0] ref_crc(input logic [31:0] d, input int nbytes);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < nbytes; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ d[8*i + j]) c = (c >> 1) ^ 16'hA001;
                else                   c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_bit(input bit b, input bit stuffable);
        if (!b) mline = toggle(mline);
        sb.push_back(mline);
        if (stuffable) begin
            mones = b ? mones + 1 : 0;
            if (mones == 6) begin
                mline = toggle(mline);
                sb.push_back(mline);
                mones = 0;
            end
        end
    endtask

    task automatic build_expected(input vec_t v, output int active_bits);
        logic [7:0]  pidb;
        logic [15:0] crc;
        int          nb;
        sb.delete();
        mline = 2'b10;
        mones = 0;
        if (!ref_legal(v.pid)) begin
            repeat (3) sb.push_back(2'b10);
            active_bits = 0;
            return;
        end
        for (int i = 0; i < 8; i++) push_bit(i == 7, 1'b0);
        pidb = {~v.pid, v.pid};
        for (int i = 0; i < 8; i++) push_bit(pidb[i], 1'b1);
        if (v.pid[1:0] == 2'b11) begin
            nb = (v.n_valid < int'(v.len)) ? v.n_valid : int'(v.len);
            for (int i = 0; i < nb; i++)
                for (int j = 0; j < 8; j++) push_bit(v.data[8*i + j], 1'b1);
            if (v.n_valid >= int'(v.len)) begin
                crc = ref_crc(v.data, int'(v.len));
                for (int i = 0; i < 16; i++) push_bit(crc[i], 1'b1);
            end
        end
        sb.push_back(2'b00);
        sb.push_back(2'b00);
        sb.push_back(2'b10);
        active_bits = sb.size();
        sb.push_back(2'b10);   // idle after EOP
    endtask

    // ---------------- drivers ----------------
    task automatic feed(input vec_t v, input int k);
        int guard;
        for (int i = 0; i < v.n_valid; i++) begin
            tx_data       = v.data[8*i +: 8];
            tx_data_valid = 1'b1;
            guard = 0;
            while (tx_data_ready !== 1'b1 && guard < WAIT_LIMIT) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("vec%0d ready wait byte%0d", k, i), 32'(guard < WAIT_LIMIT), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        tx_data_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int    active, b0, d0, e0, r0, nbit, exp_busy;
        line_t exp_l;
        build_expected(v, active);
        @(negedge clk);
        b0 = busy_cyc; d0 = done_cnt; e0 = err_cnt; r0 = ready_cyc;
        tx_pid   = v.pid;
        tx_len   = v.len;
        tx_start = 1'b1;
        fork
            begin
                @(posedge clk);
                @(negedge clk);
                tx_start = 1'b0;
                repeat (3) @(negedge clk);
                nbit = 0;
                while (sb.size() > 0) begin
                    exp_l = sb.pop_front();
                    check($sformatf("vec%0d line bit%0d", k, nbit), 32'({dp, dm}), 32'(exp_l));
                    nbit++;
                    repeat (CPB) @(negedge clk);
                end
            end
            feed(v, k);
        join
        exp_busy = ((v.exp_bits != 0) ? v.exp_bits : active) * CPB;
        check($sformatf("vec%0d busy cycles", k), 32'(busy_cyc - b0), 32'(exp_busy));
        check($sformatf("vec%0d done pulses", k), 32'(done_cnt - d0), 32'(v.exp_done));
        check($sformatf("vec%0d error pulses", k), 32'(err_cnt - e0), 32'(v.exp_err));
        if (v.no_ready)
            check($sformatf("vec%0d ready cycles", k), 32'(ready_cyc - r0), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        //          pid      len  data          nv done err bits noready
        vecs[0] = '{4'b0010, 7'd5, 32'h0,        0, 1,  0,  19,  1'b1}; // ACK, len ignored
        vecs[1] = '{4'b0011, 7'd0, 32'h0,        0, 1,  0,  35,  1'b1}; // DATA0 empty
        vecs[2] = '{4'b1011, 7'd2, 32'h0000FFFF, 2, 1,  0,  0,   1'b0}; // DATA1 FF FF
        vecs[3] = '{4'b0011, 7'd4, 32'h78563412, 2, 0,  1,  0,   1'b0}; // underrun at byte 3
        vecs[4] = '{4'b0101, 7'd0, 32'h0,        0, 0,  1,  0,   1'b1}; // illegal PID
        vecs[5] = '{4'b1010, 7'd0, 32'h0,        0, 1,  0,  19,  1'b1}; // NAK
        vecs[6] = '{4'b1110, 7'd0, 32'h0,        0, 1,  0,  19,  1'b1}; // STALL
        vecs[7] = '{4'b0011, 7'd3, 32'h007E00A5, 3, 1,  0,  0,   1'b0}; // DATA0 A5 00 7E
        vecs[8] = '{4'b1011, 7'd4, 32'h01FEFF3F, 4, 1,  0,  0,   1'b0}; // stuffing across bytes

        rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; tx_len = '0;
        tx_data = 8'h00; tx_data_valid = 1'b0;
        #1;
        check("reset dp/dm", 32'({dp, dm}), 32'h2);
        check("reset busy", 32'(tx_busy), 32'd0);
        check("reset done", 32'(tx_done), 32'd0);
        check("reset error", 32'(tx_error), 32'd0);
        check("reset ready", 32'(tx_data_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

        // Illegal PID: error exactly one cycle after the start, line stays J.
        @(negedge clk);
        tx_pid = 4'b0101; tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        check("illegal pid error pulse", 32'(tx_error), 32'd1);
        check("illegal pid busy", 32'(tx_busy), 32'd0);
        check("illegal pid line", 32'({dp, dm}), 32'h2);
        @(negedge clk);
        check("illegal pid error clears", 32'(tx_error), 32'd0);

        // Reset in the middle of DATA aborts at once without EOP.
        @(negedge clk);
        tx_pid = 4'b0011; tx_len = 7'd4; tx_start = 1'b1;
        tx_data = 8'h00; tx_data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (24 * CPB) @(negedge clk);
        check("mid-data busy before reset", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        tx_data_valid = 1'b0;
        #1;
        check("mid-data reset line", 32'({dp, dm}), 32'h2);
        check("mid-data reset busy", 32'(tx_busy), 32'd0);
        check("mid-data reset ready", 32'(tx_data_ready), 32'd0);
        @(negedge clk);
        check("mid-data reset line held", 32'({dp, dm}), 32'h2);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
